uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/common_pkg.sv | 51 +++++
 rtl/uart_baud_tick.sv | 35 +++
 rtl/uart_tx.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/common_pkg.sv
// Shared UART definitions: register map, LCR field layout, data-length encoding
// and the transmitter state type.
package common_pkg;

  localparam logic [3:0] ADDR_OCR = 4'h0;
  localparam logic [3:0] ADDR_TDR = 4'h4;
  localparam logic [3:0] ADDR_LCR = 4'h8;
  localparam logic [3:0] ADDR_DIV = 4'hC;

  localparam int LCR_DATA_BITS_LSB  = 0;
  localparam int LCR_DATA_BITS_MSB  = 1;
  localparam int LCR_STOP_BIT       = 2;
  localparam int LCR_PARITY_EN_BIT  = 3;
  localparam int LCR_PARITY_ODD_BIT = 4;
  localparam int LCR_WIDTH          = 5;

  localparam logic [1:0] DB_5 = 2'b00;
  localparam logic [1:0] DB_6 = 2'b01;
  localparam logic [1:0] DB_7 = 2'b10;
  localparam logic [1:0] DB_8 = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  function automatic logic [3:0] data_len(input logic [1:0] db);
    case (db)
      DB_5:    data_len = 4'd5;
      DB_6:    data_len = 4'd6;
      DB_7:    data_len = 4'd7;
      DB_8:    data_len = 4'd8;
      default: data_len = 4'd8;
    endcase
  endfunction

  // Selects the payload bits that actually go on the line (used for parity).
  function automatic logic [7:0] data_mask(input logic [1:0] db);
    case (db)
      DB_5:    data_mask = 8'h1F;
      DB_6:    data_mask = 8'h3F;
      DB_7:    data_mask = 8'h7F;
      DB_8:    data_mask = 8'hFF;
      default: data_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable bit-period down-counter; o_tick marks the last cycle of each bit and
// the counter reloads the latched divisor on that cycle.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_run,
  input  logic                 i_load,
  input  logic [DIV_WIDTH-1:0] i_divisor,
  output logic                 o_tick
);

  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_div <= i_divisor;
      r_cnt <= i_divisor;
    end else if (!i_run) begin
      r_cnt <= '0;
    end else if (r_cnt == '0) begin
      r_cnt <= r_div;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tick = i_run && (r_cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 5-8 data bits, optional even/odd parity, 1 or 2 stop bits,
// programmable bit period. Frame settings are latched when a frame is accepted.
module uart_tx
  import common_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_en_i,
  input  logic                 start_i,
  input  logic [7:0]           tx_data_i,
  input  logic [1:0]           data_bits_i,
  input  logic                 stop_bits_i,
  input  logic                 parity_en_i,
  input  logic                 parity_odd_i,
  input  logic [DIV_WIDTH-1:0] divisor_i,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  tx_state_e            r_state, w_state_next;
  logic                 r_tx, w_tx_next;
  logic                 r_busy, w_busy_next;
  logic                 r_done, w_done_next;
  logic [7:0]           r_shift, w_shift_next;
  logic [3:0]           r_bit_cnt, w_bit_cnt_next;
  logic                 r_stop_cnt, w_stop_cnt_next;
  logic [LCR_WIDTH-1:0] r_lcr, w_lcr_next;
  logic                 r_parity, w_parity_next;
  logic                 w_load;
  logic                 w_tick;
  logic [3:0]           w_len;

  uart_baud_tick #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .i_run    (r_state != IDLE),
    .i_load   (w_load),
    .i_divisor(divisor_i),
    .o_tick   (w_tick)
  );

  assign w_len = data_len(r_lcr[LCR_DATA_BITS_MSB:LCR_DATA_BITS_LSB]);

  always_comb begin
    w_state_next    = r_state;
    w_tx_next       = r_tx;
    w_busy_next     = r_busy;
    w_done_next     = 1'b0;
    w_shift_next    = r_shift;
    w_bit_cnt_next  = r_bit_cnt;
    w_stop_cnt_next = r_stop_cnt;
    w_lcr_next      = r_lcr;
    w_parity_next   = r_parity;
    w_load          = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_next   = 1'b1;
        w_busy_next = 1'b0;
        if (start_i && tx_en_i) begin
          w_state_next    = START;
          w_tx_next       = 1'b0;
          w_busy_next     = 1'b1;
          w_load          = 1'b1;
          w_shift_next    = tx_data_i;
          w_bit_cnt_next  = '0;
          w_stop_cnt_next = 1'b0;
          w_lcr_next[LCR_DATA_BITS_MSB:LCR_DATA_BITS_LSB] = data_bits_i;
          w_lcr_next[LCR_STOP_BIT]       = stop_bits_i;
          w_lcr_next[LCR_PARITY_EN_BIT]  = parity_en_i;
          w_lcr_next[LCR_PARITY_ODD_BIT] = parity_odd_i;
          w_parity_next = (^(tx_data_i & data_mask(data_bits_i))) ^ parity_odd_i;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_next   = DATA;
          w_tx_next      = r_shift[0];
          w_shift_next   = {1'b0, r_shift[7:1]};
          w_bit_cnt_next = 4'd1;
        end
      end
      DATA: begin
        // r_bit_cnt counts data bits already placed on the line.
        if (w_tick) begin
          if (r_bit_cnt == w_len) begin
            if (r_lcr[LCR_PARITY_EN_BIT]) begin
              w_state_next = PARITY;
              w_tx_next    = r_parity;
            end else begin
              w_state_next = STOP;
              w_tx_next    = 1'b1;
            end
          end else begin
            w_tx_next      = r_shift[0];
            w_shift_next   = {1'b0, r_shift[7:1]};
            w_bit_cnt_next = r_bit_cnt + 4'd1;
          end
        end
      end
      PARITY: begin
        if (w_tick) begin
          w_state_next = STOP;
          w_tx_next    = 1'b1;
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_lcr[LCR_STOP_BIT] && !r_stop_cnt) begin
            w_stop_cnt_next = 1'b1;
          end else begin
            w_state_next = IDLE;
            w_tx_next    = 1'b1;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_tx_next    = 1'b1;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_lcr      <= '0;
      r_parity   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_tx       <= w_tx_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
      r_shift    <= w_shift_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_stop_cnt <= w_stop_cnt_next;
      r_lcr      <= w_lcr_next;
      r_parity   <= w_parity_next;
    end
  end

  assign tx_o   = r_tx;
  assign busy_o = r_busy;
  assign done_o = r_done;

endmodule
